ro_pair_counter: RTL and testbench
==================================

RO_PAIR_COUNTER -- requirements
Module: ro_pair_counter

Interface
REQ-001 Parameter CNT_W, default 16: width of each edge counter.
REQ-002 Parameter WIN_W, default 16: width of the measurement-window length.
REQ-003 Parameter SETTLE, default 4: cycles between oscillator enable and start of counting (≥ SYNC_N).
REQ-004 Parameter SYNC_N, default 2: flip-flop stages per oscillator synchronizer (≥ 2).
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  request one measurement; sampled only in IDLE.
REQ-008 window  input  WIN_W  count-window length in clk cycles; latched when start is accepted.
REQ-009 ro_a  input  1  asynchronous output of ring oscillator A.
REQ-010 ro_b  input  1  asynchronous output of ring oscillator B.
REQ-011 ro_en  output  1  enable driven to both oscillators' enable inputs.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when results update.
REQ-014 cnt_a  output  CNT_W  held rising-edge count of ro_a from the last measurement.
REQ-015 cnt_b  output  CNT_W  held rising-edge count of ro_b from the last measurement.
REQ-016 resp  output  1  PUF response bit: 1 iff cnt_a > cnt_b.
REQ-017 tie  output  1  1 iff cnt_a == cnt_b.

Function
REQ-018 Each ro input passes through its own SYNC_N-stage synchronizer plus one edge-history flop; a rising edge is sync_out=1 with history=0.
REQ-019 FSM states: IDLE, SETTLE, COUNT, DONE.
REQ-020 IDLE: ro_en=0, busy=0; start=1 latches window (0 is replaced by 1) and moves to SETTLE on the next cycle.
REQ-021 SETTLE: ro_en=1, both working counters cleared, no edges counted; lasts exactly SETTLE cycles, then moves to COUNT.
REQ-022 COUNT: ro_en=1; each detected rising edge increments its working counter; lasts exactly the latched window cycles, then moves to DONE.
REQ-023 Working counters saturate at 2^CNT_W-1 and do not wrap.
REQ-024 DONE: ro_en=0; cnt_a, cnt_b, resp and tie load from the working counters; done=1 for this single cycle; next state is IDLE.
REQ-025 Latency: done asserts exactly 1+SETTLE+window cycles after the cycle in which start is accepted.
REQ-026 Output registers cnt_a, cnt_b, resp and tie change only in DONE or on reset.
REQ-027 start while busy=1 is ignored and is not queued.
REQ-028 start asserted in the same cycle as DONE is ignored; it is accepted if still high in the following IDLE cycle.
REQ-029 An edge detected on the final COUNT cycle is counted; edges seen in SETTLE or DONE are not counted.
REQ-030 Changes on window while busy have no effect on the measurement in progress.

Reset
REQ-031 rst=1 forces IDLE next cycle regardless of the current state, aborting any measurement without a done pulse.
REQ-032 After reset: ro_en=0, busy=0, done=0, cnt_a=0, cnt_b=0, resp=0, tie=1, working counters, synchronizers and latched window cleared.
REQ-033 rst has priority over start in the same cycle.

Verification
REQ-034 ro_a toggles every clk, ro_b every 2 clk; window=100 -> done at cycle 1+SETTLE+100; cnt_a=50±1, cnt_b=25±1, resp=1, tie=0.
REQ-035 ro_a and ro_b are identical toggle-every-clk streams; window=10 -> cnt_a=cnt_b=5±1, equal to each other; resp=0, tie=1.
REQ-036 CNT_W=4, ro_a toggles every clk, window=100 -> cnt_a=15 (saturated), resp depends on ro_b; there is no wrap to small values.
REQ-037 window=0 -> behaves as window=1; done at cycle 1+SETTLE+1; counts ≤1.
REQ-038 rst pulsed mid-COUNT -> next cycle busy=0, ro_en=0; no done pulse; outputs keep their reset values.
REQ-039 start held high continuously -> back-to-back measurements separated by exactly one IDLE cycle; start pulses while busy produce no extra done pulse.

Source files
------------

// File: rtl/ro_pair_counter.sv
// Ring-oscillator pair PUF counter: count synchronized rising edges of ro_a/ro_b over a window.
// done fires 1+SETTLE+window cycles after start is accepted; start is ignored (not queued) while busy.
module ro_pair_counter #(
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 4,
  parameter int SYNC_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             resp,
  output logic             tie
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);

  state_t state, state_nxt;

  logic [SYNC_N-1:0] sync_a, sync_b;
  logic              hist_a, hist_b;
  logic              rise_a, rise_b;

  logic [SW-1:0]    scnt;
  logic [WIN_W-1:0] wcnt;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] wrk_a, wrk_b;
  logic [CNT_W-1:0] wrk_a_nxt, wrk_b_nxt;

  // Oscillator inputs are asynchronous: full synchronizer chain, then one history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      hist_a <= 1'b0;
      hist_b <= 1'b0;
    end else begin
      sync_a <= {sync_a[SYNC_N-2:0], ro_a};
      sync_b <= {sync_b[SYNC_N-2:0], ro_b};
      hist_a <= sync_a[SYNC_N-1];
      hist_b <= sync_b[SYNC_N-1];
    end
  end

  assign rise_a = sync_a[SYNC_N-1] & ~hist_a;
  assign rise_b = sync_b[SYNC_N-1] & ~hist_b;

  // Saturating increments; the counters stick at all-ones rather than wrap.
  assign wrk_a_nxt = (rise_a && (wrk_a != '1)) ? wrk_a + CNT_W'(1) : wrk_a;
  assign wrk_b_nxt = (rise_b && (wrk_b != '1)) ? wrk_b + CNT_W'(1) : wrk_b;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ro_en     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        ro_en = 1'b1;
        if (scnt == SET_LAST) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        ro_en = 1'b1;
        if (wcnt == (win_q - WIN_W'(1))) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      scnt  <= '0;
      wcnt  <= '0;
      wrk_a <= '0;
      wrk_b <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      resp  <= 1'b0;
      tie   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            win_q <= (window == '0) ? WIN_W'(1) : window;
            scnt  <= '0;
          end
        end
        ST_SETTLE: begin
          scnt  <= scnt + SW'(1);
          wcnt  <= '0;
          wrk_a <= '0;
          wrk_b <= '0;
        end
        ST_COUNT: begin
          wcnt  <= wcnt + WIN_W'(1);
          wrk_a <= wrk_a_nxt;
          wrk_b <= wrk_b_nxt;
          // Results include an edge seen on the final count cycle and are visible while done is high.
          if (state_nxt == ST_DONE) begin
            cnt_a <= wrk_a_nxt;
            cnt_b <= wrk_b_nxt;
            resp  <= (wrk_a_nxt > wrk_b_nxt);
            tie   <= (wrk_a_nxt == wrk_b_nxt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_pair_counter.sv
// Directed bench for ro_pair_counter: latency, counts, saturation, reset abort, back-to-back starts.
module tb_ro_pair_counter;

  localparam int SET = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] window = 16'd0;
  logic        ro_a = 1'b0;
  logic        ro_b = 1'b0;

  logic        ro_en, busy, done, resp, tie;
  logic [15:0] cnt_a, cnt_b;
  logic        ro_en4, busy4, done4, resp4, tie4;
  logic [3:0]  cnt_a4, cnt_b4;

  int checks = 0;
  int failures = 0;
  int ro_mode = 0;
  bit div = 1'b0;

  ro_pair_counter #(.CNT_W(16), .WIN_W(16), .SETTLE(SET), .SYNC_N(2)) dut (
    .clk(clk), .rst(rst), .start(start), .window(window), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .busy(busy), .done(done), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .resp(resp), .tie(tie)
  );

  ro_pair_counter #(.CNT_W(4), .WIN_W(16), .SETTLE(SET), .SYNC_N(2)) dut4 (
    .clk(clk), .rst(rst), .start(start), .window(window), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en4), .busy(busy4), .done(done4), .cnt_a(cnt_a4), .cnt_b(cnt_b4),
    .resp(resp4), .tie(tie4)
  );

  always #5 clk = ~clk;

  // Oscillator models: 1 = a every clk / b every 2 clk, 2 = identical streams, 3 = a every clk / b low.
  always @(posedge clk) begin
    #1;
    div = ~div;
    case (ro_mode)
      1: begin ro_a = ~ro_a; if (div) ro_b = ~ro_b; end
      2: begin ro_a = ~ro_a; ro_b = ro_a; end
      3: begin ro_a = ~ro_a; ro_b = 1'b0; end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input logic [31:0] got, input int lo, input int hi);
    checks++;
    assert ((int'(got) >= lo) && (int'(got) <= hi)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", name, got, lo, hi);
    end
  endtask

  // Issue one start, then count cycles from the accepting edge until done is seen.
  task automatic measure(input logic [15:0] w, input int exp_lat, input string tag);
    int n;
    bit seen;
    @(posedge clk); #2;
    start = 1'b1;
    window = w;
    @(posedge clk); #2;
    start = 1'b0;
    window = 16'd3;
    n = 0;
    seen = 1'b0;
    while (!seen && (n < exp_lat + 20)) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " ro_en"}, 32'(ro_en), 32'd1);
      end
      if (done) seen = 1'b1;
    end
    chk({tag, " latency"}, n, exp_lat);
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int nd;
    int d[3];
    logic blog[0:199];
    int dones;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ro_en", 32'(ro_en), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst cnt_a", 32'(cnt_a), 32'd0);
    chk("rst cnt_b", 32'(cnt_b), 32'd0);
    chk("rst resp", 32'(resp), 32'd0);
    chk("rst tie", 32'(tie), 32'd1);

    // a twice as fast as b; window changes mid-run must not matter
    ro_mode = 1;
    repeat (4) @(posedge clk);
    measure(16'd100, 1 + SET + 100, "t1");
    chk_rng("t1 cnt_a", 32'(cnt_a), 49, 51);
    chk_rng("t1 cnt_b", 32'(cnt_b), 24, 26);
    chk("t1 resp", 32'(resp), 32'd1);
    chk("t1 tie", 32'(tie), 32'd0);
    after_done("t1");

    ro_mode = 2;
    measure(16'd10, 1 + SET + 10, "t2");
    chk_rng("t2 cnt_a", 32'(cnt_a), 4, 6);
    chk_rng("t2 cnt_b", 32'(cnt_b), 4, 6);
    chk("t2 resp", 32'(resp), 32'd0);
    chk("t2 tie", 32'(tie), 32'd1);
    after_done("t2");

    // 4-bit instance must saturate at 15
    ro_mode = 3;
    repeat (4) @(posedge clk);
    measure(16'd100, 1 + SET + 100, "t3");
    chk("t3 sat cnt_a4", 32'(cnt_a4), 32'd15);
    chk("t3 cnt_b4", 32'(cnt_b4), 32'd0);
    chk("t3 resp4", 32'(resp4), 32'd1);
    chk("t3 tie4", 32'(tie4), 32'd0);
    chk_rng("t3 wide cnt_a", 32'(cnt_a), 49, 51);
    after_done("t3");

    ro_mode = 1;
    measure(16'd0, 1 + SET + 1, "t4");
    chk_rng("t4 cnt_a", 32'(cnt_a), 0, 1);
    chk_rng("t4 cnt_b", 32'(cnt_b), 0, 1);
    after_done("t4");

    // reset mid-COUNT aborts with no done
    @(posedge clk); #2;
    start = 1'b1;
    window = 16'd100;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (SET + 10) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 ro_en", 32'(ro_en), 32'd0);
    chk("t5 cnt_a", 32'(cnt_a), 32'd0);
    chk("t5 cnt_b", 32'(cnt_b), 32'd0);
    chk("t5 resp", 32'(resp), 32'd0);
    chk("t5 tie", 32'(tie), 32'd1);
    dones = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("t5 no done", dones, 0);
    chk("t5 cnt_a held", 32'(cnt_a), 32'd0);

    // rst wins over start in the same cycle
    @(posedge clk); #2;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("t6 rst priority", 32'(busy), 32'd0);

    // start held high: one IDLE cycle between runs
    repeat (2) @(posedge clk);
    #2 start = 1'b1;
    window = 16'd5;
    nd = 0;
    for (int i = 0; i < 3; i++) d[i] = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      blog[c] = busy;
      if (done && nd < 3) begin
        d[nd] = c;
        nd++;
      end
    end
    start = 1'b0;
    chk("t7 done count", nd, 3);
    chk("t7 gap 1", d[1] - d[0], 2 + SET + 5);
    chk("t7 gap 2", d[2] - d[1], 2 + SET + 5);
    if (d[0] >= 0 && d[0] < 197) begin
      chk("t7 idle after done", 32'(blog[d[0] + 1]), 32'd0);
      chk("t7 busy again", 32'(blog[d[0] + 2]), 32'd1);
    end else begin
      chk("t7 first done seen", d[0], 1 + SET + 5);
    end

    repeat (20) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
